// File: rtl/processor_mem_arb_pkg.sv
// Shared widths, latency and requester ids for the on-chip RAM arbiter.
package processor_mem_arb_pkg;

   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_BE_W       = DEF_DATA_W / 8;
   localparam int RAM_RD_LATENCY = 1;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } req_id_t;

endpackage

// File: rtl/processor_rr_arb2.sv
// Two-way round-robin grant; owns the last_grant history bit.
module processor_rr_arb2
   import processor_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       freeze,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic last_grant;

   always_comb begin
      gnt_id = M0;
      if (req == 2'b10)
         gnt_id = M1;
      else if (req == 2'b11)
         gnt_id = ~last_grant;
      // Holding the grant off while in reset keeps the RAM idle during reset.
      gnt = 2'b00;
      if (reset_n && !freeze && (req != 2'b00))
         gnt = (gnt_id == M1) ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last_grant <= M1;
      else if (gnt != 2'b00)
         last_grant <= gnt_id;
   end

endmodule

// File: rtl/processor_onchip_memory_arbiter.sv
// Shares the single-port on-chip RAM between the CPU data master (m0) and
// the DMA/debug master (m1); routes one-cycle-late read data back to the issuer.
module processor_onchip_memory_arbiter
   import processor_mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int BE_W   = DEF_BE_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              freeze,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
);

   logic [1:0] req;
   logic [1:0] gnt;
   logic       gnt_id;
   logic       any_gnt;
   logic       sel_m1;
   logic       sel_wr;
   logic       rd_gnt;
   logic       rd_pend;
   logic       rd_id;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   processor_rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .freeze  (freeze),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id)
   );

   assign any_gnt = |gnt;
   // With no grant the mux defaults to m0; the RAM ignores it (chipselect low).
   assign sel_m1  = gnt[1];
   // Read+write together counts as a write.
   assign sel_wr  = sel_m1 ? m1_write : m0_write;
   assign rd_gnt  = any_gnt & ~sel_wr;

   assign m0_waitrequest = ~gnt[0];
   assign m1_waitrequest = ~gnt[1];

   assign ram_address    = sel_m1 ? m1_address   : m0_address;
   assign ram_writedata  = sel_m1 ? m1_writedata : m0_writedata;
   assign ram_byteenable = sel_wr ? (sel_m1 ? m1_byteenable : m0_byteenable) : {BE_W{1'b1}};
   assign ram_chipselect = any_gnt;
   assign ram_write      = any_gnt & sel_wr;
   assign ram_clken      = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend <= 1'b0;
         rd_id   <= M0;
      end else begin
         rd_pend <= rd_gnt;
         if (rd_gnt)
            rd_id <= gnt_id;
      end
   end

   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;
   assign m0_readdatavalid = rd_pend & (rd_id == M0);
   assign m1_readdatavalid = rd_pend & (rd_id == M1);

endmodule

// File: tb/tb_processor_onchip_memory_arbiter.sv
// Randomized + directed bench: reference model predicts grants and read returns,
// a separate monitor pops the expected-read queues as the DUT returns data.
module tb_processor_onchip_memory_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic freeze = 1'b0;
   logic [AW-1:0] m0_address, m1_address;
   logic [BW-1:0] m0_byteenable, m1_byteenable;
   logic m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] ram_address;
   logic [BW-1:0] ram_byteenable;
   logic [DW-1:0] ram_writedata;
   logic ram_chipselect, ram_write, ram_clken;
   logic [DW-1:0] ram_readdata;

   processor_onchip_memory_arbiter dut (
      .clk(clk), .reset_n(reset_n), .freeze(freeze),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
      .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural single-port RAM driven by the DUT.
   logic [DW-1:0] ram [1024];
   logic [DW-1:0] ram_q = '0;
   always @(posedge clk) begin
      if (ram_chipselect && ram_clken) begin
         if (ram_write) begin
            for (int b = 0; b < BW; b++)
               if (ram_byteenable[b]) ram[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
         end else begin
            ram_q <= ram[ram_address];
         end
      end
   end
   assign ram_readdata = ram_q;

   // Reference model state: expected memory contents and expected read returns.
   typedef struct { int due; logic [DW-1:0] data; } exp_t;
   exp_t q0[$];
   exp_t q1[$];
   logic [DW-1:0] shadow [1024];
   int last_w = 1;
   int chk = 0;
   int errs = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: who should be granted this cycle, and what the RAM side should show.
   always @(negedge clk) begin
      logic r0, r1, has, wr;
      int w;
      logic [AW-1:0] a;
      logic [BW-1:0] be;
      logic [DW-1:0] d;
      exp_t e;
      check("clken", ram_clken, 1);
      if (!reset_n) begin
         last_w = 1;
         q0.delete();
         q1.delete();
         check("rst_wait0", m0_waitrequest, 1);
         check("rst_wait1", m1_waitrequest, 1);
         check("rst_cs", ram_chipselect, 0);
         check("rst_wr", ram_write, 0);
      end else begin
         r0 = m0_read | m0_write;
         r1 = m1_read | m1_write;
         has = !freeze && (r0 || r1);
         w = (r0 && r1) ? 1 - last_w : (r1 ? 1 : 0);
         wr = (w == 1) ? m1_write : m0_write;
         check("wait0", m0_waitrequest, !(has && w == 0));
         check("wait1", m1_waitrequest, !(has && w == 1));
         check("cs", ram_chipselect, has);
         check("ram_write", ram_write, has && wr);
         if (has) begin
            last_w = w;
            a  = (w == 1) ? m1_address : m0_address;
            be = (w == 1) ? m1_byteenable : m0_byteenable;
            d  = (w == 1) ? m1_writedata : m0_writedata;
            check("ram_addr", ram_address, a);
            check("ram_be", ram_byteenable, wr ? be : 4'hF);
            if (wr) begin
               check("ram_wdata", ram_writedata, d);
               for (int b = 0; b < BW; b++)
                  if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
               e.due = cyc + 1;
               e.data = shadow[a];
               if (w == 1) q1.push_back(e); else q0.push_back(e);
            end
         end
      end
   end

   // Monitor: every readdatavalid must match the oldest expected return due now.
   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_rdv0", m0_readdatavalid, 0);
         check("rst_rdv1", m1_readdatavalid, 0);
      end else begin
         if (m0_readdatavalid) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
               check("rd0_data", m0_readdata, q0[0].data);
               void'(q0.pop_front());
            end else begin
               chk++; errs++;
               $display("FAIL rd0_unexpected: got readdatavalid=1 expected 0 (cycle %0d)", cyc);
            end
         end else if (q0.size() > 0 && q0[0].due == cyc) begin
            chk++; errs++;
            $display("FAIL rd0_missing: got readdatavalid=0 expected 1 (cycle %0d)", cyc);
            void'(q0.pop_front());
         end
         if (m1_readdatavalid) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
               check("rd1_data", m1_readdata, q1[0].data);
               void'(q1.pop_front());
            end else begin
               chk++; errs++;
               $display("FAIL rd1_unexpected: got readdatavalid=1 expected 0 (cycle %0d)", cyc);
            end
         end else if (q1.size() > 0 && q1[0].due == cyc) begin
            chk++; errs++;
            $display("FAIL rd1_missing: got readdatavalid=0 expected 1 (cycle %0d)", cyc);
            void'(q1.pop_front());
         end
      end
   end

   task automatic drv(input int id, input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] d);
      if (id == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
      end
   endtask

   task automatic idle();
      drv(0, 0, 0, '0, '0, '0);
      drv(1, 0, 0, '0, '0, '0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] v;
      for (int i = 0; i < 1024; i++) begin
         v = i * 32'h9E3779B1;
         ram[i] = v;
         shadow[i] = v;
      end
      ram[10'h005] = 32'hDEADBEEF; shadow[10'h005] = 32'hDEADBEEF;
      ram[10'h3FF] = 32'hAAAAAAAA; shadow[10'h3FF] = 32'hAAAAAAAA;
      idle();

      // Both masters read continuously from reset: m0 first, then alternate.
      drv(0, 1, 0, 10'h001, 4'h0, '0);
      drv(1, 1, 0, 10'h002, 4'h0, '0);
      repeat (3) step();
      reset_n = 1'b1;
      @(negedge clk);
      check("first_win_m0", m0_waitrequest, 0);
      check("first_lose_m1", m1_waitrequest, 1);
      repeat (8) step();
      idle();
      repeat (2) step();

      // m0 reads 0x005.
      drv(0, 1, 0, 10'h005, 4'h0, '0);
      step();
      idle();
      @(negedge clk);
      check("rd5_valid", m0_readdatavalid, 1);
      check("rd5_data", m0_readdata, 32'hDEADBEEF);
      step();

      // m1 partial write to 0x3FF, then read back next cycle.
      drv(1, 0, 1, 10'h3FF, 4'b0011, 32'h12345678);
      step();
      drv(1, 1, 0, 10'h3FF, 4'h0, '0);
      step();
      idle();
      @(negedge clk);
      check("be_merge_valid", m1_readdatavalid, 1);
      check("be_merge_data", m1_readdata, 32'hAAAA5678);
      step();

      // m0 read+write together is a write.
      drv(0, 1, 1, 10'h010, 4'hF, 32'h00000055);
      step();
      idle();
      @(negedge clk);
      check("rw_no_rdv", m0_readdatavalid, 0);
      step();
      drv(0, 1, 0, 10'h010, 4'h0, '0);
      step();
      idle();
      @(negedge clk);
      check("rw_readback", m0_readdata, 32'h00000055);
      step();

      // Freeze for 3 cycles; the read issued just before still returns.
      drv(0, 1, 0, 10'h005, 4'h0, '0);
      step();
      freeze = 1'b1;
      drv(0, 1, 0, 10'h007, 4'h0, '0);
      drv(1, 1, 0, 10'h008, 4'h0, '0);
      @(negedge clk);
      check("frz_return", m0_readdatavalid, 1);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         check("frz_cs", ram_chipselect, 0);
         step();
      end
      freeze = 1'b0;
      idle();
      step();

      // Reset right after an m1 read issue drops the return.
      drv(1, 1, 0, 10'h3FF, 4'h0, '0);
      step();
      reset_n = 1'b0;
      idle();
      @(negedge clk);
      check("rst_drop_rdv1", m1_readdatavalid, 0);
      step();
      reset_n = 1'b1;
      drv(0, 1, 0, 10'h003, 4'h0, '0);
      drv(1, 1, 0, 10'h004, 4'h0, '0);
      @(negedge clk);
      check("post_rst_m0_wins", m0_waitrequest, 0);
      check("post_rst_rdv1", m1_readdatavalid, 0);
      step();
      idle();
      repeat (2) step();

      // Randomized traffic, with occasional freeze and reset.
      for (int n = 0; n < 600; n++) begin
         for (int id = 0; id < 2; id++) begin
            int k;
            logic [AW-1:0] a;
            k = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            if (k < 3)      drv(id, 0, 0, a, 4'($urandom), $urandom);
            else if (k < 7) drv(id, 1, 0, a, 4'($urandom), $urandom);
            else if (k < 9) drv(id, 0, 1, a, 4'($urandom), $urandom);
            else            drv(id, 1, 1, a, 4'($urandom), $urandom);
         end
         freeze  = ($urandom_range(0, 9) == 0);
         reset_n = ($urandom_range(0, 99) != 0);
         step();
      end
      reset_n = 1'b1;
      freeze = 1'b0;
      idle();
      repeat (3) step();
      @(negedge clk);
      check("sb_drained", 32'(q0.size() + q1.size()), 0);

      $display("Result: errors=%0d of %0d checks", errs, chk);
      $finish;
   end

endmodule

// File: doc/processor_onchip_memory_arbiter.md
# processor_onchip_memory_arbiter

Two-requester arbiter that shares the single-port 1024×32 on-chip RAM between the CPU data master (m0) and a DMA/debug master (m1). The RAM accepts at most one access per clock and returns read data one cycle after issue. The arbiter grants one requester per cycle using round-robin. It generates the RAM chipselect, write and clken, and routes the one-cycle-late read data back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width (1024 words)
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)

Ports:
- clk  in  1  single clock for all logic and the RAM
- reset_n  in  1  asynchronous, active-low reset
- freeze  in  1  when high, no new grants are issued; accesses already issued still complete
- mN_address  in  ADDR_W  word address (N = 0, 1)
- mN_byteenable  in  BE_W  byte lanes for a write; ignored for a read
- mN_read  in  1  read request
- mN_write  in  1  write request
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data, valid only with mN_readdatavalid
- mN_readdatavalid  out  1  one-cycle pulse that accompanies read data
- ram_address  out  ADDR_W  address of the granted request
- ram_byteenable  out  BE_W  byte enables of the granted write; all ones for a read
- ram_writedata  out  DATA_W  write data of the granted write
- ram_chipselect  out  1  high in a grant cycle
- ram_write  out  1  high in a write grant cycle
- ram_clken  out  1  constant 1
- ram_readdata  in  DATA_W  RAM q output, valid the cycle after a read issue

## Operation
- Request: reqN = mN_read | mN_write.
- Illegal case: if mN_read and mN_write are both high, the access is treated as a write and the read is ignored.
- Round-robin arbitration:
  - The grant is computed combinationally from reqN and a registered last_grant bit.
  - When both masters request, the one not named by last_grant wins.
  - last_grant updates only in a cycle where a grant is issued.
- freeze high: both grants are forced to 0, both waitrequests are high, and last_grant holds.
- Grant cycle for requester g:
  - mg_waitrequest = 0; the losing requester's waitrequest = 1.
  - ram_* outputs are driven from mg_*.
- No grant: ram_chipselect = 0 and ram_write = 0; ram_address and ram_writedata are don't-care (driven from m0).
- Read return tracking:
  - A registered pair rd_pend (1 bit) and rd_id (1 bit) is set when a read is granted.
  - In the next cycle, m[rd_id]_readdatavalid = 1 and m[rd_id]_readdata = ram_readdata (combinational pass-through).
  - rd_pend is cleared unless another read is granted in the same cycle.
- Back-to-back reads, same or alternating masters, sustain one access per cycle with no bubble.
- Writes produce no readdatavalid.
- mN_readdata is driven with ram_readdata at all times; consumers qualify it with readdatavalid.

## Timing
- Reset (reset_n low, asynchronous): last_grant = 1 (so m0 wins the first contention), rd_pend = 0, rd_id = 0.
- Outputs while in reset: both waitrequests = 1, both readdatavalids = 0, ram_chipselect = 0, ram_write = 0.
- Request-to-accept latency: 0 cycles when uncontended; waitrequest is combinational from the request inputs, last_grant and freeze.
- Read latency: issue in cycle N, readdatavalid in cycle N+1, exactly one cycle.
- Write latency: the RAM is written at the rising edge that ends the grant cycle. A read of the same address in cycle N+1 returns the new data.
- Worst-case wait under contention: 1 cycle, because round-robin alternates grants.
- freeze asserted in cycle N: any read granted in N-1 still returns in N; no grant is issued in N.
- reset_n asserted mid-read: the pending readdatavalid is dropped and not issued after reset is released.
- A requester must hold its address and data stable while its waitrequest is high (Avalon rule); the arbiter does not latch requests.

## Structure
- Package processor_mem_arb_pkg holds:
  - ADDR_W, DATA_W, BE_W defaults
  - RAM_RD_LATENCY = 1
  - a 1-bit requester-id typedef with constants M0 = 0 and M1 = 1
- Sub-module processor_rr_arb2:
  - inputs: req[1:0], freeze, clk, reset_n
  - outputs: gnt[1:0] (one-hot or zero), gnt_id
  - owns the last_grant register
- The top level contains the request muxing, the rd_pend/rd_id pipeline and the readdata routing.

## Test plan
- Reset, then m0 reads address 0x005 holding 0xDEADBEEF: m0_waitrequest = 0 in the issue cycle, then m0_readdatavalid = 1 with m0_readdata = 0xDEADBEEF exactly one cycle later.
- m0 and m1 both read continuously starting from reset: grants go m0, m1, m0, m1; each waitrequest is high on alternate cycles; readdatavalid alternates m0/m1 with no idle cycles.
- m1 writes 0x12345678 to 0x3FF with byteenable = 4'b0011, then reads 0x3FF the next cycle (old value 0xAAAAAAAA): readdata = 0xAAAA5678.
- m0 asserts read and write together at 0x010 with data 0x55: a write is performed, no readdatavalid is generated, and a later read returns 0x55.
- freeze held high for 3 cycles while both masters request: ram_chipselect = 0 and both waitrequests = 1 for those cycles; a read issued the cycle before freeze still returns its data.
- reset_n pulsed low in the cycle after an m1 read issue: m1_readdatavalid stays 0; after release, m0 wins the first contention.
